peripheral_arbiter_wb: RTL and testbench
========================================

// Module: peripheral_arbiter_wb
// PURPOSE
//   Round-robin Wishbone B3 arbiter that shares one slave port among NUM_MASTERS masters.
//   Sits between the peripheral masters (DMA, debug, CPU data port) and a shared slave or
//   interconnect segment.
//   Grant is held for the owner's whole cycle (cyc high), including CTI/BTE bursts.
//   A bus watchdog terminates stalled transfers with err.
// PARAMETERS
//   NUM_MASTERS  4    number of requesting masters, 2..8
//   AW           32   address width
//   DW           32   data width; sel width = DW/8
//   TIMEOUT      255  cycles of stb-without-termination before watchdog err; 0 disables it
// PORTS
//   wb_clk_i  in   1              clock; all state on rising edge
//   wb_rst_i  in   1              synchronous reset, active-high
//   m_cyc_i   in   NUM_MASTERS    per-master cyc
//   m_stb_i   in   NUM_MASTERS    per-master stb
//   m_we_i    in   NUM_MASTERS    per-master we
//   m_adr_i   in   NUM_MASTERS*AW  flattened, master k at [k*AW +: AW]
//   m_dat_i   in   NUM_MASTERS*DW  flattened write data
//   m_sel_i   in   NUM_MASTERS*DW/8  flattened byte selects
//   m_cti_i   in   NUM_MASTERS*3  flattened cycle type
//   m_bte_i   in   NUM_MASTERS*2  flattened burst type
//   m_dat_o   out  DW             slave read data, broadcast to all masters
//   m_ack_o   out  NUM_MASTERS    ack, routed only to the owner
//   m_err_o   out  NUM_MASTERS    err (slave or watchdog), owner only
//   m_rty_o   out  NUM_MASTERS    rty, owner only
//   s_cyc_o, s_stb_o, s_we_o  out  1    to slave
//   s_adr_o   out  AW;  s_dat_o  out  DW;  s_sel_o  out  DW/8;  s_cti_o  out  3;  s_bte_o  out  2
//   s_dat_i   in   DW;  s_ack_i, s_err_i, s_rty_i  in  1
//   grant_o   out  NUM_MASTERS    one-hot current owner; all-zero when idle
// BEHAVIOUR
//   States
//     IDLE  -> GRANT when any m_cyc_i is high at the clock edge.
//     GRANT -> IDLE when owner's m_cyc_i is low at the clock edge, or on watchdog fire.
//   Arbitration
//     Search starts at last_owner+1 modulo NUM_MASTERS; first master with cyc high wins.
//     last_owner resets to NUM_MASTERS-1, so master 0 has first priority after reset.
//   Latency and release
//     A request in IDLE gives a registered grant; the slave sees cyc one cycle after m_cyc_i.
//     A release costs one IDLE cycle before the next grant (no back-to-back handoff).
//   Forwarding
//     In GRANT, s_* = owner's m_* combinationally; owner's m_ack/err/rty = s_ack/err/rty.
//     Non-owners see ack/err/rty = 0 and stall.
//     In IDLE: s_cyc_o = s_stb_o = s_we_o = 0, s_cti_o = CLASSIC (000), s_bte_o = LINEAR (00);
//     adr/dat/sel are driven 0.
//   Bursts
//     No re-arbitration inside a burst; END_OF_BURST does not release, only cyc low does.
//   Watchdog
//     wd_cnt (8+ bits, sized to TIMEOUT) clears on IDLE, on any s_ack/err/rty, or when s_stb_o is low.
//     It increments while s_stb_o is high with no termination.
//     When wd_cnt == TIMEOUT: register a one-cycle m_err_o to the owner; that cycle s_cyc_o = s_stb_o = 0;
//     then go to IDLE.
//     The master must drop cyc; if it still holds cyc, it is re-arbitrated normally.
//   Simultaneous events
//     s_ack_i in the same cycle wd_cnt reaches TIMEOUT: ack wins, counter clears, no err.
//     Owner drops cyc while another requests: IDLE one cycle, then round-robin from the old owner+1.
//   Reset
//     Forces IDLE, grant_o = 0, wd_cnt = 0, all m_ack/err/rty = 0, last_owner = NUM_MASTERS-1.
//     Reset mid-burst aborts the burst: s_cyc_o = 0 on the cycle after the reset edge.
// TESTING
//   1. All four masters assert cyc in cycle 0 after reset -> grants in order 0,1,2,3,0;
//      one IDLE cycle between grants.
//   2. M2 INC_BURST, WRAP_4, 4 beats from adr 0x1C -> slave sees adr 0x1C,0x10,0x14,0x18;
//      M1 requesting meanwhile is not granted until M2 cyc drops.
//   3. Slave never acks, TIMEOUT=255 -> exactly one m_err_o[owner] pulse 256 cycles after stb;
//      s_cyc_o low that cycle; then IDLE.
//   4. s_ack_i on the cycle wd_cnt==TIMEOUT -> ack delivered, no err.
//   5. s_err_i/s_rty_i from slave -> forwarded only to owner; non-owners read 0.
//   6. wb_rst_i mid-burst (beat 2 of 4) -> next cycle s_cyc_o=0, grant_o=0;
//      after release, master 0 gets priority.

Source files
------------

// File: rtl/peripheral_arbiter_wb.sv
// peripheral_arbiter_wb: round-robin Wishbone B3 arbiter sharing one slave port.
// The owner keeps the bus for its whole cyc; a watchdog errors out stalled transfers.
module peripheral_arbiter_wb #(
  parameter int NUM_MASTERS = 4,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
  output logic [DW-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic [NUM_MASTERS-1:0]      m_rty_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  output logic                        s_we_o,
  output logic [AW-1:0]               s_adr_o,
  output logic [DW-1:0]               s_dat_o,
  output logic [DW/8-1:0]             s_sel_o,
  output logic [2:0]                  s_cti_o,
  output logic [1:0]                  s_bte_o,
  input  logic [DW-1:0]               s_dat_i,
  input  logic                        s_ack_i,
  input  logic                        s_err_i,
  input  logic                        s_rty_i,
  output logic [NUM_MASTERS-1:0]      grant_o
);

  localparam int SW = DW / 8;
  localparam int LW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = (TW > 8) ? TW : 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    WD_ERR = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] owner_q, owner_d;
  logic [LW-1:0] last_q, last_d;
  logic [CW-1:0] wd_cnt_q, wd_cnt_d;

  logic [AW-1:0] adr_a [NUM_MASTERS];
  logic [DW-1:0] dat_a [NUM_MASTERS];
  logic [SW-1:0] sel_a [NUM_MASTERS];
  logic [2:0]    cti_a [NUM_MASTERS];
  logic [1:0]    bte_a [NUM_MASTERS];

  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
    assign adr_a[k] = m_adr_i[k*AW +: AW];
    assign dat_a[k] = m_dat_i[k*DW +: DW];
    assign sel_a[k] = m_sel_i[k*SW +: SW];
    assign cti_a[k] = m_cti_i[k*3 +: 3];
    assign bte_a[k] = m_bte_i[k*2 +: 2];
  end

  logic own_cyc;
  logic own_stb;
  logic term;
  logic wd_fire;

  assign own_cyc = m_cyc_i[owner_q];
  assign own_stb = own_cyc & m_stb_i[owner_q];
  assign term    = s_ack_i | s_err_i | s_rty_i;
  assign wd_fire = (TIMEOUT != 0) && own_stb && !term &&
                   (wd_cnt_q == CW'(TIMEOUT));

  // Round-robin search starting just after the previous owner.
  logic [LW-1:0] winner;
  logic [LW-1:0] idx;
  logic          any_req;

  always_comb begin
    winner  = last_q;
    idx     = '0;
    any_req = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = LW'((int'(last_q) + i) % NUM_MASTERS);
      if (!any_req && m_cyc_i[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      last_q   <= LW'(NUM_MASTERS - 1);
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    wd_cnt_d = '0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          owner_d = winner;
          last_d  = winner;
        end
      end
      GRANT: begin
        if (!own_cyc) begin
          state_d = IDLE;
        end else if (wd_fire) begin
          state_d = WD_ERR;
        end else if (own_stb && !term) begin
          wd_cnt_d = wd_cnt_q + CW'(1);
        end
      end
      WD_ERR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The watchdog cycle keeps grant so the owner can see its err pulse.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_cti_o = 3'b000;
    s_bte_o = 2'b00;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    grant_o = '0;
    unique case (state_q)
      GRANT: begin
        grant_o[owner_q] = 1'b1;
        s_cyc_o          = own_cyc;
        s_stb_o          = own_stb;
        s_we_o           = m_we_i[owner_q];
        s_adr_o          = adr_a[owner_q];
        s_dat_o          = dat_a[owner_q];
        s_sel_o          = sel_a[owner_q];
        s_cti_o          = cti_a[owner_q];
        s_bte_o          = bte_a[owner_q];
        m_ack_o[owner_q] = s_ack_i;
        m_err_o[owner_q] = s_err_i;
        m_rty_o[owner_q] = s_rty_i;
      end
      WD_ERR: begin
        grant_o[owner_q] = 1'b1;
        m_err_o[owner_q] = 1'b1;
      end
      default: ;
    endcase
  end

  assign m_dat_o = s_dat_i;

endmodule

// File: tb/tb_peripheral_arbiter_wb.sv
// tb_peripheral_arbiter_wb: vector table, directed burst/watchdog/reset
// sequences and a randomized run against a cycle-level reference model.
module tb_peripheral_arbiter_wb;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 255;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat;
  logic [N*SW-1:0] m_sel;
  logic [N*3-1:0]  m_cti;
  logic [N*2-1:0]  m_bte;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack, m_err, m_rty, grant;
  logic            s_cyc, s_stb, s_we;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_o;
  logic [SW-1:0]   s_sel;
  logic [2:0]      s_cti;
  logic [1:0]      s_bte;
  logic [DW-1:0]   s_dat_i;
  logic            s_ack, s_err, s_rty;

  logic [AW-1:0] adr_a [N];
  logic [DW-1:0] dat_a [N];
  logic [SW-1:0] sel_a [N];
  logic [2:0]    cti_a [N];
  logic [1:0]    bte_a [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign m_adr[g*AW +: AW] = adr_a[g];
    assign m_dat[g*DW +: DW] = dat_a[g];
    assign m_sel[g*SW +: SW] = sel_a[g];
    assign m_cti[g*3 +: 3]   = cti_a[g];
    assign m_bte[g*2 +: 2]   = bte_a[g];
  end

  peripheral_arbiter_wb #(
    .NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(TO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_cti_i(m_cti), .m_bte_i(m_bte),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack), .m_err_o(m_err), .m_rty_o(m_rty),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_sel_o(s_sel),
    .s_cti_o(s_cti), .s_bte_o(s_bte),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .grant_o(grant)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0;
    for (int k = 0; k < N; k++) begin
      adr_a[k] = '0; dat_a[k] = '0; sel_a[k] = '0;
      cti_a[k] = '0; bte_a[k] = '0;
    end
    s_dat_i = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  // Reference model: owner index (-1 idle), last owner, stall cycles.
  int own = -1;
  int last = N - 1;
  int stall = 0;
  bit wderr = 1'b0;

  task automatic model_check();
    logic [N-1:0]  e_grant, e_ack, e_err, e_rty;
    logic          e_cyc, e_stb, e_we;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [SW-1:0] e_sel;
    logic [4:0]    e_cb;
    e_grant = '0; e_ack = '0; e_err = '0; e_rty = '0;
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
    e_adr = '0; e_dat = '0; e_sel = '0; e_cb = '0;
    if (own >= 0) e_grant = N'(1) << own;
    if (wderr) begin
      e_err = e_grant;
    end else if (own >= 0) begin
      e_cyc = m_cyc[IW'(own)];
      e_stb = e_cyc & m_stb[IW'(own)];
      e_we  = m_we[IW'(own)];
      e_adr = adr_a[own];
      e_dat = dat_a[own];
      e_sel = sel_a[own];
      e_cb  = {cti_a[own], bte_a[own]};
      if (s_ack) e_ack = e_grant;
      if (s_err) e_err = e_grant;
      if (s_rty) e_rty = e_grant;
    end
    chk("rnd_grant", grant, e_grant);
    chk("rnd_cyc_stb_we", {s_cyc, s_stb, s_we}, {e_cyc, e_stb, e_we});
    chk("rnd_adr", s_adr, e_adr);
    chk("rnd_dat", s_dat_o, e_dat);
    chk("rnd_sel", s_sel, e_sel);
    chk("rnd_cti_bte", {s_cti, s_bte}, e_cb);
    chk("rnd_ack", m_ack, e_ack);
    chk("rnd_err", m_err, e_err);
    chk("rnd_rty", m_rty, e_rty);
    chk("rnd_rdata", m_dat_o, s_dat_i);
  endtask

  task automatic model_advance();
    if (rst) begin
      own = -1; last = N - 1; stall = 0; wderr = 1'b0;
    end else if (wderr) begin
      wderr = 1'b0; own = -1; stall = 0;
    end else if (own < 0) begin
      for (int i = 1; i <= N; i++)
        if (own < 0 && m_cyc[IW'((last + i) % N)]) own = (last + i) % N;
      if (own >= 0) last = own;
      stall = 0;
    end else if (!m_cyc[IW'(own)]) begin
      own = -1; stall = 0;
    end else if (m_stb[IW'(own)] && !(s_ack || s_err || s_rty)) begin
      if (TO != 0 && stall == TO) begin
        wderr = 1'b1; stall = 0;
      end else begin
        stall++;
      end
    end else begin
      stall = 0;
    end
  endtask

  typedef struct {
    logic [N-1:0] cyc;
    logic [N-1:0] stb;
    logic         ack, err, rty;
    logic [N-1:0] e_grant;
    logic         e_cyc;
    logic [N-1:0] e_ack, e_err, e_rty;
  } vec_t;

  vec_t tbl[16];

  logic [AW-1:0] burst_adr [4];
  logic [AW-1:0] a;
  bit            early_err;
  bit            cyc_lost;

  initial begin
    tbl[0]  = '{4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 4'h1, 1'b1, 4'h1, 4'h0, 4'h0};
    tbl[2]  = '{4'hE, 4'hF, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 4'h0, 4'h0, 4'h0};
    tbl[3]  = '{4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0};
    tbl[4]  = '{4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 4'h2, 1'b1, 4'h2, 4'h0, 4'h0};
    tbl[5]  = '{4'hD, 4'hF, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 4'h0, 4'h0, 4'h0};
    tbl[6]  = '{4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0};
    tbl[7]  = '{4'hF, 4'hF, 1'b0, 1'b1, 1'b0, 4'h4, 1'b1, 4'h0, 4'h4, 4'h0};
    tbl[8]  = '{4'hB, 4'hF, 1'b0, 1'b0, 1'b0, 4'h4, 1'b0, 4'h0, 4'h0, 4'h0};
    tbl[9]  = '{4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0};
    tbl[10] = '{4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 4'h8, 1'b1, 4'h0, 4'h0, 4'h8};
    tbl[11] = '{4'h7, 4'hF, 1'b0, 1'b0, 1'b0, 4'h8, 1'b0, 4'h0, 4'h0, 4'h0};
    tbl[12] = '{4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0};
    tbl[13] = '{4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 4'h1, 1'b1, 4'h1, 4'h0, 4'h0};
    tbl[14] = '{4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 4'h0, 4'h0, 4'h0};
    tbl[15] = '{4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0};
    burst_adr[0] = 32'h1C; burst_adr[1] = 32'h10;
    burst_adr[2] = 32'h14; burst_adr[3] = 32'h18;

    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    do_reset();

    #1;
    chk("reset_grant", grant, 4'h0);
    chk("reset_s_cyc_stb", {s_cyc, s_stb}, 2'b00);
    chk("reset_cti_bte", {s_cti, s_bte}, 5'b0);
    chk("reset_resp", {m_ack, m_err, m_rty}, 12'h0);

    // Round-robin order 0,1,2,3,0 with an idle cycle per handoff.
    for (int i = 0; i < 16; i++) begin
      m_cyc = tbl[i].cyc; m_stb = tbl[i].stb;
      s_ack = tbl[i].ack; s_err = tbl[i].err; s_rty = tbl[i].rty;
      #1;
      chk($sformatf("tbl%0d_grant", i), grant, tbl[i].e_grant);
      chk($sformatf("tbl%0d_s_cyc", i), s_cyc, tbl[i].e_cyc);
      chk($sformatf("tbl%0d_ack", i), m_ack, tbl[i].e_ack);
      chk($sformatf("tbl%0d_err", i), m_err, tbl[i].e_err);
      chk($sformatf("tbl%0d_rty", i), m_rty, tbl[i].e_rty);
      step();
    end

    // M2 wrap-4 burst from 0x1C while M1 waits.
    do_reset();
    m_cyc = 4'b0100; m_stb = 4'b0100;
    adr_a[2] = 32'h1C; cti_a[2] = 3'b010; bte_a[2] = 2'b01;
    step();
    m_cyc = 4'b0110; m_stb = 4'b0110;
    for (int b = 0; b < 4; b++) begin
      a = (32'h1C & ~32'hF) | ((32'h1C + 32'(4 * b)) & 32'hF);
      adr_a[2] = a;
      cti_a[2] = (b == 3) ? 3'b111 : 3'b010;
      s_ack = 1'b1;
      #1;
      chk($sformatf("burst%0d_adr", b), s_adr, burst_adr[b]);
      chk($sformatf("burst%0d_grant", b), grant, 4'b0100);
      chk($sformatf("burst%0d_ack", b), m_ack, 4'b0100);
      chk($sformatf("burst%0d_cti_bte", b), {s_cti, s_bte},
          {((b == 3) ? 3'b111 : 3'b010), 2'b01});
      step();
    end
    s_ack = 1'b0;
    #1;
    chk("burst_eob_holds", grant, 4'b0100);
    m_cyc = 4'b0010; m_stb = 4'b0010;
    step();
    #1;
    chk("burst_release_idle", grant, 4'b0000);
    chk("burst_release_s_cyc", s_cyc, 1'b0);
    step();
    #1;
    chk("burst_next_m1", grant, 4'b0010);
    m_cyc = '0; m_stb = '0;
    step();
    step();

    // Watchdog: slave never terminates.
    do_reset();
    m_cyc = 4'b0001; m_stb = 4'b0001;
    step();
    early_err = 1'b0; cyc_lost = 1'b0;
    for (int k = 0; k < 256; k++) begin
      #1;
      if (m_err !== 4'b0) early_err = 1'b1;
      if (s_cyc !== 1'b1 || s_stb !== 1'b1) cyc_lost = 1'b1;
      step();
    end
    chk("wd_no_early_err", early_err, 1'b0);
    chk("wd_cyc_held", cyc_lost, 1'b0);
    #1;
    chk("wd_err_pulse", m_err, 4'b0001);
    chk("wd_s_cyc_stb_low", {s_cyc, s_stb}, 2'b00);
    step();
    m_cyc = '0; m_stb = '0;
    #1;
    chk("wd_after_idle", grant, 4'b0000);
    chk("wd_err_single", m_err, 4'b0000);
    step();

    // Ack on the timeout cycle wins over the watchdog.
    do_reset();
    m_cyc = 4'b0001; m_stb = 4'b0001;
    step();
    for (int k = 0; k < 255; k++) step();
    s_ack = 1'b1;
    #1;
    chk("wdack_ack", m_ack, 4'b0001);
    chk("wdack_no_err", m_err, 4'b0000);
    step();
    s_ack = 1'b0;
    #1;
    chk("wdack_no_err_next", m_err, 4'b0000);
    chk("wdack_still_owner", {grant, s_cyc}, {4'b0001, 1'b1});
    m_cyc = '0; m_stb = '0;
    step();
    step();

    // Reset mid-burst, then master 0 is first in line.
    do_reset();
    m_cyc = 4'b0010; m_stb = 4'b0010; cti_a[1] = 3'b010;
    step();
    s_ack = 1'b1;
    #1;
    chk("rstb_beat1_grant", grant, 4'b0010);
    step();
    s_ack = 1'b0;
    rst = 1'b1;
    m_cyc = 4'b0111; m_stb = 4'b0111;
    step();
    rst = 1'b0;
    #1;
    chk("rstb_s_cyc", s_cyc, 1'b0);
    chk("rstb_grant", grant, 4'b0000);
    step();
    #1;
    chk("rstb_m0_first", grant, 4'b0001);
    m_cyc = '0; m_stb = '0;
    step();
    step();

    // Randomized traffic against the reference model.
    do_reset();
    own = -1; last = N - 1; stall = 0; wderr = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 7) == 0) m_cyc[IW'(k)] = ~m_cyc[IW'(k)];
        m_stb[IW'(k)] = ($urandom_range(0, 3) != 0);
        m_we[IW'(k)]  = 1'($urandom_range(0, 1));
        adr_a[k] = $urandom;
        dat_a[k] = $urandom;
        sel_a[k] = 4'($urandom);
        cti_a[k] = 3'($urandom);
        bte_a[k] = 2'($urandom);
      end
      s_dat_i = $urandom;
      s_ack = ($urandom_range(0, 2) == 0);
      s_err = ($urandom_range(0, 15) == 0);
      s_rty = ($urandom_range(0, 15) == 0);
      #1;
      model_check();
      model_advance();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
